// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution lane: bus widths, RV32I opcode
// constants and truth/enable levels used by the reservation-station datapath.
package alu_exec_pkg;

    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ROB_W  = 4;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_W-1:0] OP_LB    = 6'd11;
    localparam logic [OP_W-1:0] OP_LH    = 6'd12;
    localparam logic [OP_W-1:0] OP_LW    = 6'd13;
    localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
    localparam logic [OP_W-1:0] OP_SB    = 6'd16;
    localparam logic [OP_W-1:0] OP_SH    = 6'd17;
    localparam logic [OP_W-1:0] OP_SW    = 6'd18;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
    localparam logic [OP_W-1:0] OP_OR    = 6'd36;
    localparam logic [OP_W-1:0] OP_AND   = 6'd37;

    // Immediate-form opcodes take their second operand from RS_A instead of RS_Vk.
    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        return op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                          OP_SLLI, OP_SRLI, OP_SRAI, OP_JALR};
    endfunction

endpackage

// File: rtl/alu_cmp.sv
// Shared comparator for the SLT* results and the conditional-branch decision.
module alu_cmp
    import alu_exec_pkg::*;
(
    input  logic [DATA_W-1:0] vj,
    input  logic [DATA_W-1:0] vk,
    input  logic [OP_W-1:0]   op,
    output logic              eq,
    output logic              lt_signed,
    output logic              lt_unsigned,
    output logic              cond
);

    assign eq          = (vj == vk);
    assign lt_signed   = ($signed(vj) < $signed(vk));
    assign lt_unsigned = (vj < vk);

    // Non-branch opcodes never request a redirect.
    always_comb begin
        cond = FALSE;
        case (op)
            OP_BEQ:  cond = eq;
            OP_BNE:  cond = !eq;
            OP_BLT:  cond = lt_signed;
            OP_BGE:  cond = !lt_signed;
            OP_BLTU: cond = lt_unsigned;
            OP_BGEU: cond = !lt_unsigned;
            default: cond = FALSE;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Single-cycle RV32I integer unit driving the ALU lane of the CDB one cycle after issue.
// Optional issue/taken performance counters are built when ALU_PERF_CNT_EN is defined.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              RS_S,
    input  logic [OP_W-1:0]   RS_Op,
    input  logic [DATA_W-1:0] RS_Vj,
    input  logic [DATA_W-1:0] RS_Vk,
    input  logic [DATA_W-1:0] RS_A,
    input  logic [ROB_W-1:0]  RS_Reorder,
    input  logic [ADDR_W-1:0] RS_pc,
    output logic              CDB_S,
    output logic [ROB_W-1:0]  CDB_Reorder,
    output logic [DATA_W-1:0] CDB_Value,
    output logic              CDB_Jump,
    output logic [ADDR_W-1:0] CDB_Target
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]       Perf_Issue,
    output logic [31:0]       Perf_Taken
`endif
);

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [ADDR_W-1:0] pc_plus_a;
    logic [ADDR_W-1:0] pc_plus_4;
    logic [4:0]        shamt;
    logic              accepted;

    logic              cmp_eq_unused;
    logic              cmp_lt_s;
    logic              cmp_lt_u;
    logic              cmp_cond;

    logic [DATA_W-1:0] result;
    logic              jump;
    logic [ADDR_W-1:0] target;

    assign op_b      = uses_imm(RS_Op) ? RS_A : RS_Vk;
    assign sum       = RS_Vj + op_b;
    assign diff      = RS_Vj - op_b;
    assign pc_plus_a = RS_pc + RS_A;
    assign pc_plus_4 = RS_pc + 32'd4;
    assign shamt     = op_b[4:0];

    // clr outranks rdy, both outrank issue; either one simply drops the slot.
    assign accepted  = RS_S && (clr == DISABLE) && (rdy == ENABLE);

    // Equality is already folded into cmp_cond for BEQ/BNE.
    alu_cmp u_cmp (
        .vj          (RS_Vj),
        .vk          (op_b),
        .op          (RS_Op),
        .eq          (cmp_eq_unused),
        .lt_signed   (cmp_lt_s),
        .lt_unsigned (cmp_lt_u),
        .cond        (cmp_cond)
    );

    // Unknown opcodes fall through to zero so the ROB still sees its tag complete.
    always_comb begin
        result = '0;
        jump   = FALSE;
        target = '0;
        case (RS_Op)
            OP_LUI:   result = RS_A;
            OP_AUIPC: result = pc_plus_a;
            OP_JAL:   result = pc_plus_4;
            OP_JALR: begin
                result = pc_plus_4;
                jump   = TRUE;
                target = {sum[31:1], 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                jump   = cmp_cond;
                target = pc_plus_a;
            end
            OP_ADD, OP_ADDI:   result = sum;
            OP_SUB:            result = diff;
            OP_XOR, OP_XORI:   result = RS_Vj ^ op_b;
            OP_OR,  OP_ORI:    result = RS_Vj | op_b;
            OP_AND, OP_ANDI:   result = RS_Vj & op_b;
            OP_SLT, OP_SLTI:   result = {31'd0, cmp_lt_s};
            OP_SLTU, OP_SLTIU: result = {31'd0, cmp_lt_u};
            OP_SLL, OP_SLLI:   result = RS_Vj << shamt;
            OP_SRL, OP_SRLI:   result = RS_Vj >> shamt;
            OP_SRA, OP_SRAI:   result = 32'($signed(RS_Vj) >>> shamt);
            default: begin
                result = '0;
                jump   = FALSE;
                target = '0;
            end
        endcase
    end

    // Data fields only move on an accepted issue; consumers qualify them with CDB_S.
    always_ff @(posedge clk) begin
        if (rst) begin
            CDB_S       <= 1'b0;
            CDB_Reorder <= '0;
            CDB_Value   <= '0;
            CDB_Jump    <= 1'b0;
            CDB_Target  <= '0;
        end else begin
            CDB_S <= accepted;
            if (accepted) begin
                CDB_Reorder <= RS_Reorder;
                CDB_Value   <= result;
                CDB_Jump    <= jump;
                CDB_Target  <= target;
            end
        end
    end

`ifdef ALU_PERF_CNT_EN
    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            Perf_Issue <= '0;
            Perf_Taken <= '0;
        end else if (accepted) begin
            Perf_Issue <= Perf_Issue + 32'd1;
            if (jump) begin
                Perf_Taken <= Perf_Taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; counter checks build with ALU_PERF_CNT_EN.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              clr;
    logic              RS_S;
    logic [OP_W-1:0]   RS_Op;
    logic [DATA_W-1:0] RS_Vj;
    logic [DATA_W-1:0] RS_Vk;
    logic [DATA_W-1:0] RS_A;
    logic [ROB_W-1:0]  RS_Reorder;
    logic [ADDR_W-1:0] RS_pc;
    logic              CDB_S;
    logic [ROB_W-1:0]  CDB_Reorder;
    logic [DATA_W-1:0] CDB_Value;
    logic              CDB_Jump;
    logic [ADDR_W-1:0] CDB_Target;
`ifdef ALU_PERF_CNT_EN
    logic [31:0]       Perf_Issue;
    logic [31:0]       Perf_Taken;
`endif

    int checks = 0;
    int errors = 0;

    alu_exec dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clr         (clr),
        .RS_S        (RS_S),
        .RS_Op       (RS_Op),
        .RS_Vj       (RS_Vj),
        .RS_Vk       (RS_Vk),
        .RS_A        (RS_A),
        .RS_Reorder  (RS_Reorder),
        .RS_pc       (RS_pc),
        .CDB_S       (CDB_S),
        .CDB_Reorder (CDB_Reorder),
        .CDB_Value   (CDB_Value),
        .CDB_Jump    (CDB_Jump),
        .CDB_Target  (CDB_Target)
`ifdef ALU_PERF_CNT_EN
        ,
        .Perf_Issue  (Perf_Issue),
        .Perf_Taken  (Perf_Taken)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one issue slot, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic s, input logic [OP_W-1:0] op,
                                 input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [31:0] a, input logic [ROB_W-1:0] tag,
                                 input logic [31:0] pc);
        RS_S       = s;
        RS_Op      = op;
        RS_Vj      = vj;
        RS_Vk      = vk;
        RS_A       = a;
        RS_Reorder = tag;
        RS_pc      = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef ALU_PERF_CNT_EN
    logic [OP_W-1:0] perf_ops [10] = '{OP_ADD, OP_BEQ, OP_SUB, OP_BNE, OP_ADD,
                                       OP_BLT, OP_XOR, OP_BGE, OP_LUI, OP_AND};
    logic [31:0]     perf_vj  [10] = '{1, 1, 9, 1, 2, 5, 3, 5, 0, 7};
    logic [31:0]     perf_vk  [10] = '{2, 1, 4, 2, 2, 3, 3, 3, 0, 1};
`endif

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        RS_S = 1'b0;
        RS_Op = OP_NOP;
        RS_Vj = '0;
        RS_Vk = '0;
        RS_A = '0;
        RS_Reorder = '0;
        RS_pc = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_S", {31'd0, CDB_S}, 32'd0);
        checkOutput("rst_tag", {28'd0, CDB_Reorder}, 32'd0);
        checkOutput("rst_val", CDB_Value, 32'd0);
        checkOutput("rst_jump", {31'd0, CDB_Jump}, 32'd0);
        checkOutput("rst_tgt", CDB_Target, 32'd0);

        applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 4'd1, 32'd0);
        checkOutput("rst_issue_S", {31'd0, CDB_S}, 32'd0);
        rst = 1'b0;

        applyStimulus(1'b1, OP_SUB, 32'd5, 32'd7, 32'd0, 4'd3, 32'd0);
        checkOutput("sub_S", {31'd0, CDB_S}, 32'd1);
        checkOutput("sub_tag", {28'd0, CDB_Reorder}, 32'd3);
        checkOutput("sub_val", CDB_Value, 32'hFFFF_FFFE);
        checkOutput("sub_jump", {31'd0, CDB_Jump}, 32'd0);
        checkOutput("sub_tgt", CDB_Target, 32'd0);

        applyStimulus(1'b0, OP_ADD, 32'd9, 32'd9, 32'd0, 4'd4, 32'd0);
        checkOutput("idle_S", {31'd0, CDB_S}, 32'd0);
        checkOutput("idle_hold", CDB_Value, 32'hFFFF_FFFE);

        applyStimulus(1'b1, OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 4'd2, 32'd0);
        checkOutput("srai_val", CDB_Value, 32'hF800_0000);
        applyStimulus(1'b1, OP_SLTIU, 32'd1, 32'd0, 32'hFFFF_FFFF, 4'd2, 32'd0);
        checkOutput("sltiu_val", CDB_Value, 32'd1);
        applyStimulus(1'b1, OP_SLTI, 32'd1, 32'd0, 32'hFFFF_FFFF, 4'd2, 32'd0);
        checkOutput("slti_val", CDB_Value, 32'd0);
        applyStimulus(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd2, 32'd0);
        checkOutput("add_wrap", CDB_Value, 32'd1);
        applyStimulus(1'b1, OP_SLL, 32'd1, 32'h21, 32'd0, 4'd2, 32'd0);
        checkOutput("sll_shamt", CDB_Value, 32'd2);
        applyStimulus(1'b1, OP_SRL, 32'h8000_0000, 32'd31, 32'd0, 4'd2, 32'd0);
        checkOutput("srl_val", CDB_Value, 32'd1);
        applyStimulus(1'b1, OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 4'd2, 32'd0);
        checkOutput("lui_val", CDB_Value, 32'h1234_5000);
        applyStimulus(1'b1, OP_AUIPC, 32'd0, 32'd0, 32'h10, 4'd2, 32'h1000);
        checkOutput("auipc_val", CDB_Value, 32'h1010);

        applyStimulus(1'b1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd6, 32'h100);
        checkOutput("blt_jump", {31'd0, CDB_Jump}, 32'd1);
        checkOutput("blt_tgt", CDB_Target, 32'h120);
        checkOutput("blt_val", CDB_Value, 32'd0);
        applyStimulus(1'b1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd6, 32'h100);
        checkOutput("bltu_jump", {31'd0, CDB_Jump}, 32'd0);

        applyStimulus(1'b1, OP_JALR, 32'h1003, 32'd0, 32'd4, 4'd7, 32'h40);
        checkOutput("jalr_val", CDB_Value, 32'h44);
        checkOutput("jalr_jump", {31'd0, CDB_Jump}, 32'd1);
        checkOutput("jalr_tgt", CDB_Target, 32'h1006);
        applyStimulus(1'b1, OP_JAL, 32'd0, 32'd0, 32'h80, 4'd7, 32'h200);
        checkOutput("jal_val", CDB_Value, 32'h204);
        checkOutput("jal_jump", {31'd0, CDB_Jump}, 32'd0);
        checkOutput("jal_tgt", CDB_Target, 32'd0);

        applyStimulus(1'b1, 6'h3F, 32'd5, 32'd5, 32'd5, 4'd9, 32'h10);
        checkOutput("unk_S", {31'd0, CDB_S}, 32'd1);
        checkOutput("unk_tag", {28'd0, CDB_Reorder}, 32'd9);
        checkOutput("unk_val", CDB_Value, 32'd0);
        checkOutput("unk_jump", {31'd0, CDB_Jump}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_ADDI, 32'd10, 32'd0, 32'(i), 4'(5 + i), 32'd0);
            checkOutput("b2b_S", {31'd0, CDB_S}, 32'd1);
            checkOutput("b2b_tag", {28'd0, CDB_Reorder}, 32'(5 + i));
            checkOutput("b2b_val", CDB_Value, 32'(10 + i));
        end
        applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        checkOutput("b2b_end_S", {31'd0, CDB_S}, 32'd0);

        applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 4'd8, 32'd0);
        checkOutput("pre_clr_S", {31'd0, CDB_S}, 32'd1);
        clr = 1'b1;
        applyStimulus(1'b1, OP_ADD, 32'd3, 32'd3, 32'd0, 4'd10, 32'd0);
        checkOutput("clr_S", {31'd0, CDB_S}, 32'd0);
        checkOutput("clr_tag_hold", {28'd0, CDB_Reorder}, 32'd8);
        clr = 1'b0;

        rdy = 1'b0;
        applyStimulus(1'b1, OP_ADD, 32'd3, 32'd3, 32'd0, 4'd11, 32'd0);
        checkOutput("rdy_S", {31'd0, CDB_S}, 32'd0);
        checkOutput("rdy_val_hold", CDB_Value, 32'd2);
        rdy = 1'b1;

`ifdef ALU_PERF_CNT_EN
        rst = 1'b1;
        applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        rst = 1'b0;
        checkOutput("perf_rst_issue", Perf_Issue, 32'd0);
        checkOutput("perf_rst_taken", Perf_Taken, 32'd0);
        for (int i = 0; i < 10; i++) begin
            clr = (i == 4);
            applyStimulus(1'b1, perf_ops[i], perf_vj[i], perf_vk[i], 32'h8, 4'(i), 32'h100);
        end
        clr = 1'b0;
        checkOutput("perf_issue", Perf_Issue, 32'd9);
        checkOutput("perf_taken", Perf_Taken, 32'd3);
        rdy = 1'b0;
        repeat (5) applyStimulus(1'b1, OP_BEQ, 32'd1, 32'd1, 32'h8, 4'd1, 32'h0);
        rdy = 1'b1;
        checkOutput("perf_hold_issue", Perf_Issue, 32'd9);
        checkOutput("perf_hold_taken", Perf_Taken, 32'd3);
`endif

        RS_S = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
